// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg: shared types and constants for the serializer and its downstream detector
package bit_serializer_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WIDTH = 8;
  localparam bit DEF_IDLE_LEVEL = 1'b0;
  localparam logic [3:0] PATTERN = 4'b1100;
endpackage

// File: rtl/bit_serializer_if.sv
// bit_serializer_if: word handshake in, serial bit stream out
interface bit_serializer_if import bit_serializer_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic x_out;
  logic bit_valid;
  logic last_bit;
  logic busy;
  modport master (output din, din_valid, input din_ready, x_out, bit_valid, last_bit, busy);
  modport slave (input din, din_valid, output din_ready, x_out, bit_valid, last_bit, busy);
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial feeder with a one-word holding register for gapless streaming
module bit_serializer import bit_serializer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input logic clk,
  input logic reset,
  bit_serializer_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state;
  logic [WIDTH-1:0] sreg, hold, nxt_word;
  logic [CW-1:0] cnt;
  logic hold_full, accept, at_last;
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction
  function automatic logic [WIDTH-1:0] shift(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w << 1 : w >> 1;
  endfunction
  assign s.din_ready = !reset && !hold_full;
  assign s.busy = (state == SHIFT) || hold_full;
  assign accept = s.din_valid && s.din_ready;
  assign at_last = (state == SHIFT) && (cnt == LAST);
  assign nxt_word = hold_full ? hold : s.din;
  // x_out holds the bit currently on the wire; sreg holds the bits still to come
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      sreg <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      cnt <= '0;
      s.x_out <= IDLE_LEVEL;
      s.bit_valid <= 1'b0;
      s.last_bit <= 1'b0;
    end else if ((state == IDLE && accept) || (at_last && (hold_full || accept))) begin
      state <= SHIFT;
      sreg <= shift(nxt_word);
      hold_full <= 1'b0;
      cnt <= '0;
      s.x_out <= first_bit(nxt_word);
      s.bit_valid <= 1'b1;
      s.last_bit <= 1'b0;
    end else if (state == SHIFT && !at_last) begin
      if (accept) begin
        hold <= s.din;
        hold_full <= 1'b1;
      end
      sreg <= shift(sreg);
      cnt <= cnt + 1'b1;
      s.x_out <= first_bit(sreg);
      s.last_bit <= (cnt + 1'b1) == LAST;
    end else begin
      state <= IDLE;
      s.x_out <= IDLE_LEVEL;
      s.bit_valid <= 1'b0;
      s.last_bit <= 1'b0;
    end
endmodule
